// File: rtl/avalon_gpio_irq.sv
// Avalon-MM GPIO slave: synchronised, optionally debounced inputs with
// per-bit edge capture and a maskable level IRQ, plus a set/clear output register.
module avalon_gpio_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_CAP  = 3'd3;
    localparam logic [2:0] A_RISE = 3'd4;
    localparam logic [2:0] A_FALL = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign filt = sync_out;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                logic [CW-1:0] cnt_q;
                logic          filt_q;
                // Counter only runs while the synced input disagrees with filt
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q  <= '0;
                        filt_q <= 1'b0;
                    end else if (sync_out[b] == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        filt_q <= sync_out[b];
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                assign filt[b] = filt_q;
            end
        end
    endgenerate

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] prev_q;
    logic [31:0]      rd_q, rd_d;
    logic [WIDTH-1:0] wd, clr, edge_hit;
    logic             wr;

    assign wr       = chipselect & ~write_n;
    assign wd       = writedata[WIDTH-1:0];
    assign edge_hit = (filt & ~prev_q & rise_q) | (~filt & prev_q & fall_q);

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        clr    = '0;
        if (wr) begin
            case (address)
                A_DATA, A_OUT: out_d  = wd;
                A_MASK:        mask_d = wd;
                A_CAP:         clr    = wd;
                A_RISE:        rise_d = wd;
                A_FALL:        fall_d = wd;
                A_SET:         out_d  = out_q | wd;
                A_CLR:         out_d  = out_q & ~wd;
                default:       ;
            endcase
        end
        // A new edge beats a coincident clear on the same bit
        cap_d = (cap_q & ~clr) | edge_hit;
    end

    always_comb begin
        rd_d = '0;
        case (address)
            A_DATA:  rd_d[WIDTH-1:0] = filt;
            A_OUT:   rd_d[WIDTH-1:0] = out_q;
            A_MASK:  rd_d[WIDTH-1:0] = mask_q;
            A_CAP:   rd_d[WIDTH-1:0] = cap_q;
            A_RISE:  rd_d[WIDTH-1:0] = rise_q;
            A_FALL:  rd_d[WIDTH-1:0] = fall_q;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            prev_q <= '0;
            rd_q   <= '0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            prev_q <= filt;
            rd_q   <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign out_port = out_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_gpio_irq.sv
// Bench for avalon_gpio_irq: a default build and a DEBOUNCE_CYCLES=4 build
// share one bus and input port; both are compared to a cycle model every cycle.
module tb_avalon_gpio_irq;

    localparam int W    = 10;
    localparam int S    = 2;
    localparam int DEB1 = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd1;
    logic [W-1:0]  op0, op1;
    logic          irq0, irq1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avalon_gpio_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd0), .in_port(in_port), .out_port(op0), .irq(irq0)
    );

    avalon_gpio_irq #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .in_port(in_port), .out_port(op1), .irq(irq1)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file per build, input history as a queue
    logic [W-1:0] m_out [2];
    logic [W-1:0] m_mask[2];
    logic [W-1:0] m_cap [2];
    logic [W-1:0] m_ren [2];
    logic [W-1:0] m_fen [2];
    logic [W-1:0] m_filt[2];
    logic [W-1:0] m_prev[2];
    logic [31:0]  m_rd  [2];
    int           m_run [2][W];
    logic [W-1:0] hist[$];
    logic [W-1:0] t_so, t_f, t_ed, t_clr, t_wd;
    logic         t_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < 2; m++) begin
                m_out[m]  = '0;
                m_mask[m] = '0;
                m_cap[m]  = '0;
                m_ren[m]  = '0;
                m_fen[m]  = '0;
                m_filt[m] = '0;
                m_prev[m] = '0;
                m_rd[m]   = '0;
                for (int b = 0; b < W; b++) m_run[m][b] = 0;
            end
            hist.delete();
            repeat (S) hist.push_back('0);
        end else begin
            t_wd = writedata[W-1:0];
            t_wr = chipselect && !write_n;
            t_so = hist[S-1];
            for (int m = 0; m < 2; m++) begin
                t_f  = (m == 0) ? t_so : m_filt[m];
                t_ed = (t_f & ~m_prev[m] & m_ren[m])
                     | (~t_f & m_prev[m] & m_fen[m]);
                case (address)
                    3'd0:    m_rd[m] = 32'(t_f);
                    3'd1:    m_rd[m] = 32'(m_out[m]);
                    3'd2:    m_rd[m] = 32'(m_mask[m]);
                    3'd3:    m_rd[m] = 32'(m_cap[m]);
                    3'd4:    m_rd[m] = 32'(m_ren[m]);
                    3'd5:    m_rd[m] = 32'(m_fen[m]);
                    default: m_rd[m] = 32'd0;
                endcase
                t_clr = (t_wr && address == 3'd3) ? t_wd : '0;
                m_cap[m] = (m_cap[m] & ~t_clr) | t_ed;
                if (t_wr) begin
                    case (address)
                        3'd0, 3'd1: m_out[m]  = t_wd;
                        3'd2:       m_mask[m] = t_wd;
                        3'd4:       m_ren[m]  = t_wd;
                        3'd5:       m_fen[m]  = t_wd;
                        3'd6:       m_out[m]  = m_out[m] | t_wd;
                        3'd7:       m_out[m]  = m_out[m] & ~t_wd;
                        default:    ;
                    endcase
                end
                m_prev[m] = t_f;
                if (m == 1) begin
                    for (int b = 0; b < W; b++) begin
                        if (t_so[b] != m_filt[m][b]) begin
                            m_run[m][b]++;
                            if (m_run[m][b] == DEB1) begin
                                m_filt[m][b] = t_so[b];
                                m_run[m][b]  = 0;
                            end
                        end else begin
                            m_run[m][b] = 0;
                        end
                    end
                end
            end
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        check("rd0", rd0, m_rd[0]);
        check("out0", 32'(op0), 32'(m_out[0]));
        check("irq0", 32'(irq0), 32'(|(m_cap[0] & m_mask[0])));
        check("rd1", rd1, m_rd[1]);
        check("out1", 32'(op1), 32'(m_out[1]));
        check("irq1", 32'(irq1), 32'(|(m_cap[1] & m_mask[1])));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a,
                          output logic [31:0] r0, output logic [31:0] r1);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chipselect = 1'b0;
        r0 = rd0;
        r1 = rd1;
    endtask

    logic [31:0] r0, r1;

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // reset mid-traffic
        bus_wr(3'd1, 32'h155);
        bus_wr(3'd2, 32'h3FF);
        bus_wr(3'd4, 32'h3FF);
        in_port = 10'h3FF;
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        check("rst_out0", 32'(op0), 32'h0);
        check("rst_irq0", 32'(irq0), 32'h0);
        check("rst_rd0", rd0, 32'h0);
        check("rst_out1", 32'(op1), 32'h0);
        in_port = '0;
        step();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), r0, r1);
            check($sformatf("rst_reg%0d", a), r0, 32'h0);
        end

        // output aliases
        bus_wr(3'd1, 32'h0F0);
        bus_wr(3'd6, 32'h003);
        bus_wr(3'd7, 32'h010);
        check("alias_out", 32'(op0), 32'h0E3);
        bus_rd(3'd1, r0, r1);
        check("alias_rd", r0, 32'h0E3);

        // rising-only capture latency on bit0
        bus_wr(3'd4, 32'h001);
        bus_wr(3'd2, 32'h001);
        in_port[0] = 1'b1;
        step();
        check("rise_e0", 32'(irq0), 32'h0);
        step();
        check("rise_e1", 32'(irq0), 32'h0);
        step();
        check("rise_e2", 32'(irq0), 32'h1);
        in_port[0] = 1'b0;
        repeat (5) step();
        bus_rd(3'd3, r0, r1);
        check("rise_nofall", r0, 32'h001);
        bus_wr(3'd3, 32'h001);
        check("rise_clr_irq", 32'(irq0), 32'h0);
        bus_rd(3'd3, r0, r1);
        check("rise_clr_cap", r0, 32'h0);

        // any-edge capture on bit9 and set-wins
        bus_wr(3'd4, 32'h200);
        bus_wr(3'd5, 32'h200);
        bus_wr(3'd2, 32'h200);
        in_port[9] = 1'b1;
        repeat (4) step();
        bus_rd(3'd3, r0, r1);
        check("any_rise", r0, 32'h200);
        bus_wr(3'd3, 32'h200);
        bus_rd(3'd3, r0, r1);
        check("any_clr", r0, 32'h0);
        in_port[9] = 1'b0;
        repeat (4) step();
        bus_rd(3'd3, r0, r1);
        check("any_fall", r0, 32'h200);
        bus_wr(3'd3, 32'h200);
        in_port[9] = 1'b1;
        step();
        step();
        bus_wr(3'd3, 32'h200);
        bus_rd(3'd3, r0, r1);
        check("set_wins", r0, 32'h200);
        check("set_wins_irq", 32'(irq0), 32'h1);

        // debounce on the DEB=4 build, bit1
        bus_wr(3'd4, 32'h002);
        bus_wr(3'd5, 32'h000);
        repeat (10) step();
        bus_wr(3'd3, 32'h3FF);
        address = 3'd0;
        in_port[1] = 1'b1;
        repeat (3) step();
        in_port[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("deb_glitch_data", 32'(rd1[1]), 32'h0);
        end
        bus_rd(3'd3, r0, r1);
        check("deb_glitch_cap", 32'(r1[1]), 32'h0);
        address = 3'd0;
        in_port[1] = 1'b1;
        repeat (6) step();
        check("deb_pulse_pre", 32'(rd1[1]), 32'h0);
        in_port[1] = 1'b0;
        step();
        check("deb_pulse_data", 32'(rd1[1]), 32'h1);
        repeat (10) step();
        bus_rd(3'd3, r0, r1);
        check("deb_pulse_cap", 32'(r1[1]), 32'h1);

        // mask and partial clear
        bus_wr(3'd4, 32'h003);
        bus_wr(3'd3, 32'h3FF);
        bus_wr(3'd2, 32'h002);
        in_port[1:0] = 2'b11;
        repeat (4) step();
        bus_rd(3'd3, r0, r1);
        check("mask_cap", r0, 32'h003);
        check("mask_irq", 32'(irq0), 32'h1);
        bus_wr(3'd3, 32'h002);
        check("pclr_irq", 32'(irq0), 32'h0);
        bus_rd(3'd3, r0, r1);
        check("pclr_cap", r0, 32'h001);

        // random traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'($urandom);
            if (i == 300) reset_n = 1'b0;
            if (i == 303) reset_n = 1'b1;
            step();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
